// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into the 5-pixel cross window (N,W,C,E,S).
// Define STALL_EN to add the win_ready/pix_ready back-pressure handshake.
module conv_window_gen #(
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned PIX_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
`ifdef STALL_EN
    input  logic             win_ready,
    output logic             pix_ready,
`endif
    output logic [PIX_W-1:0] win_n,
    output logic [PIX_W-1:0] win_w,
    output logic [PIX_W-1:0] win_c,
    output logic [PIX_W-1:0] win_e,
    output logic [PIX_W-1:0] win_s,
    output logic             win_valid,
    output logic             frame_done
);
    localparam int unsigned   CW       = $clog2(IMG_WIDTH);
    localparam int unsigned   RW       = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {FILL, STREAM, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] win_n_q, win_n_d, win_w_q, win_w_d, win_c_q, win_c_d;
    logic [PIX_W-1:0] win_e_q, win_e_d, win_s_q, win_s_d;
    logic             win_valid_q, win_valid_d, frame_done_q, frame_done_d;

    logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
    logic [PIX_W-1:0] lb2_q [IMG_WIDTH];
    logic [PIX_W-1:0] tap1, tap2, s1_q, a1_q, a2_q, b1_q;
    logic             hold, accept, col_last, row_last, emit;

`ifdef STALL_EN
    assign pix_ready = !win_valid_q || win_ready;
    assign hold      = win_valid_q && !win_ready;
`else
    assign hold      = 1'b0;
`endif

    assign accept   = pix_valid && !hold;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign tap1     = lb1_q[IMG_WIDTH-1];
    assign tap2     = lb2_q[IMG_WIDTH-1];
    // STREAM is only entered after row 1 completes, so row>=2 is implied here.
    assign emit     = accept && (state_q == STREAM) && (col_q >= COL_TWO);

    // Line buffers and column delays: taps are rows r-1 / r-2 at column c.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[0] <= pix_in;
            lb2_q[0] <= tap1;
            for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
                lb1_q[i] <= lb1_q[i-1];
                lb2_q[i] <= lb2_q[i-1];
            end
            s1_q <= pix_in;
            a1_q <= tap1;
            a2_q <= a1_q;
            b1_q <= tap2;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        case (state_q)
            FILL:    if (accept && row_q == ROW_ONE && col_last) state_d = STREAM;
            STREAM:  if (accept && row_last && col_last) state_d = DONE;
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        win_n_d      = win_n_q;
        win_w_d      = win_w_q;
        win_c_d      = win_c_q;
        win_e_d      = win_e_q;
        win_s_d      = win_s_q;
        win_valid_d  = emit;
        frame_done_d = emit && row_last && col_last;
        if (hold) begin
            win_valid_d  = win_valid_q;
            frame_done_d = frame_done_q;
        end else if (emit) begin
            win_n_d = b1_q;
            win_w_d = a2_q;
            win_c_d = a1_q;
            win_e_d = tap1;
            win_s_d = s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_n_q      <= '0;
            win_w_q      <= '0;
            win_c_q      <= '0;
            win_e_q      <= '0;
            win_s_q      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_n_q      <= win_n_d;
            win_w_q      <= win_w_d;
            win_c_q      <= win_c_d;
            win_e_q      <= win_e_d;
            win_s_q      <= win_s_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_n      = win_n_q;
    assign win_w      = win_w_q;
    assign win_c      = win_c_q;
    assign win_e      = win_e_q;
    assign win_s      = win_s_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x5 image; handshake cases build with STALL_EN.
module tb_conv_window_gen;
    localparam int W = 5;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pix_in;
    logic       pix_valid;
    logic [3:0] win_n, win_w, win_c, win_e, win_s;
    logic       win_valid, frame_done;
    logic       rdy, wr;
    logic [19:0] win_bus;

`ifdef STALL_EN
    logic win_ready, pix_ready;
    assign rdy = pix_ready;
    assign wr  = win_ready;
`else
    assign rdy = 1'b1;
    assign wr  = 1'b1;
`endif
    assign win_bus = {win_n, win_w, win_c, win_e, win_s};

    conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
`ifdef STALL_EN
        .win_ready  (win_ready),
        .pix_ready  (pix_ready),
`endif
        .win_n      (win_n),
        .win_w      (win_w),
        .win_c      (win_c),
        .win_e      (win_e),
        .win_s      (win_s),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard entries are {frame_done, N, W, C, E, S}.
    logic [20:0] sb [$];
    logic [20:0] wlog [$];
    logic [19:0] held = '0;
    logic [3:0]  img [H][W];
    logic [3:0]  pend_pix;
    bit          pend_acc, pend_rst, armed, prev_done;
    int          mr, mc, fd_cnt, consec;

    always begin
        @(negedge clk);
        if (armed) begin
            if (win_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_win", 32'(win_valid), 0);
                end else begin
                    check_val("window", {11'd0, frame_done, win_bus}, {11'd0, sb[0]});
                    if (wr) begin
                        held = sb[0][19:0];
                        if (sb[0][20]) fd_cnt++;
                        wlog.push_back(sb.pop_front());
                    end
                end
                if (prev_done) consec++;
            end else begin
                check_val("idle_hold", {12'd0, win_bus}, {12'd0, held});
                check_val("idle_fd", 32'(frame_done), 0);
            end
            prev_done = win_valid && wr;
        end
        pend_rst = !rst_n;
        pend_acc = rst_n && pix_valid && rdy;
        pend_pix = pix_in;
        @(posedge clk);
        if (pend_rst) begin
            sb.delete();
            mr = 0; mc = 0;
            held = '0;
            prev_done = 1'b0;
            armed = 1'b1;
        end else if (pend_acc) begin
            img[mr][mc] = pend_pix;
            if (mr >= 2 && mc >= 2)
                sb.push_back({(mr == H-1 && mc == W-1) ? 1'b1 : 1'b0,
                              img[mr-2][mc-1], img[mr-1][mc-2], img[mr-1][mc-1],
                              img[mr-1][mc], img[mr][mc-1]});
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    end

    task automatic send_pix(input logic [3:0] v);
        int  guard = 0;
        bit  acc;
        pix_in    = v;
        pix_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = rdy;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check_val("accept_timeout", 32'(acc), 1);
    endtask

    task automatic send_frame(input int off, input bit gap);
        for (int i = 0; i < W*H; i++) begin
            send_pix(4'((i + off) % 16));
            if (gap) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b1, b2, b3, b4, f0, c0, guard;
        rst_n = 1'b0; pix_valid = 1'b0; pix_in = '0;
`ifdef STALL_EN
        win_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("reset_valid", 32'(win_valid), 0);
        check_val("reset_fd", 32'(frame_done), 0);
        check_val("reset_win", {12'd0, win_bus}, 0);
        @(posedge clk);
        #1;

        // continuous single frame
        b1 = wlog.size(); f0 = fd_cnt;
        send_frame(0, 1'b0);
        idle(6);
        check_val("s1_count", wlog.size() - b1, 9);
        check_val("s1_frame_done", fd_cnt - f0, 1);
        if (wlog.size() >= b1 + 9) begin
            check_val("s1_first", {11'd0, wlog[b1]}, {11'd0, 1'b0, 20'h1567B});
            check_val("s1_last", {11'd0, wlog[b1+8]}, {11'd0, 1'b1, 4'd13, 4'd1, 4'd2, 4'd3, 4'd7});
        end

        // alternate-cycle valid
        b2 = wlog.size(); f0 = fd_cnt; c0 = consec;
        send_frame(0, 1'b1);
        idle(6);
        check_val("s2_count", wlog.size() - b2, 9);
        check_val("s2_consecutive", consec - c0, 0);
        check_val("s2_frame_done", fd_cnt - f0, 1);
        if (wlog.size() >= b2 + 1)
            check_val("s2_first", {11'd0, wlog[b2]}, {11'd0, 1'b0, 20'h1567B});

        // two frames back to back, different pixel data
        b3 = wlog.size(); f0 = fd_cnt;
        send_frame(0, 1'b0);
        send_frame(9, 1'b0);
        idle(6);
        check_val("s3_count", wlog.size() - b3, 18);
        check_val("s3_frame_done", fd_cnt - f0, 2);
        if (wlog.size() >= b3 + 10)
            check_val("s3_f2_first", {11'd0, wlog[b3+9]}, {11'd0, 1'b0, 20'hAEF04});

        // mid-frame reset
        for (int i = 0; i < 8; i++) send_pix(4'(i));
        pix_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("s4_rst_valid", 32'(win_valid), 0);
        check_val("s4_rst_fd", 32'(frame_done), 0);
        check_val("s4_rst_win", {12'd0, win_bus}, 0);
        @(posedge clk);
        #1;
        b4 = wlog.size();
        send_frame(0, 1'b0);
        idle(6);
        check_val("s4_count", wlog.size() - b4, 9);
        if (wlog.size() >= b4 + 1)
            check_val("s4_first", {11'd0, wlog[b4]}, {11'd0, wlog[b1]});

`ifdef STALL_EN
        // back-pressure at the first window
        b4 = wlog.size();
        win_ready = 1'b0;
        fork
            send_frame(0, 1'b0);
            begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!win_valid && guard < 100);
                check_val("s5_seen", 32'(win_valid), 1);
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    check_val("s5_pix_ready", 32'(pix_ready), 0);
                    check_val("s5_valid", 32'(win_valid), 1);
                    check_val("s5_win", {12'd0, win_bus}, {12'd0, 20'h1567B});
                end
                @(posedge clk);
                #1 win_ready = 1'b1;
            end
        join
        idle(6);
        check_val("s5_count", wlog.size() - b4, 9);

        // reset while stalled
        win_ready = 1'b0;
        for (int i = 0; i < 13; i++) send_pix(4'(i));
        pix_valid = 1'b0;
        @(negedge clk);
        check_val("s6_stalled", 32'(win_valid), 1);
        check_val("s6_stall_rdy", 32'(pix_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        win_ready = 1'b1;
        @(negedge clk);
        check_val("s6_rst_valid", 32'(win_valid), 0);
        check_val("s6_rst_ready", 32'(pix_ready), 1);
        @(posedge clk);
        #1;
`endif

        idle(4);
        check_val("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
